// File: rtl/lsu_ctrl.sv
// Sequential load/store unit for the MEM stage: one request at a time over a req/gnt + rvalid bus,
// with alignment checking, lane-aligned byte masks, load extension, and a REQ+WAIT timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready for a request; bus quiet, stray bus_rvalid ignored
// REQ    | bus_req high with stable bus_* fields, waiting for bus_gnt
// WAIT   | granted, bus_req low, waiting for bus_rvalid
// RESP   | out_valid high with stable result, waiting for out_ready
module lsu_ctrl #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic                in_store,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_rdata,
    output logic [1:0]          out_err,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_wmask,
    input  logic                bus_rvalid,
    input  logic [XLEN-1:0]     bus_rdata,
    input  logic                bus_err
);
    localparam int NB    = XLEN / 8;
    localparam int OW    = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]       bus_wmask_q, bus_wmask_d;
    logic [OW-1:0]       off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                store_q, store_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                illegal;
    logic [NB-1:0]       lane_mask;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     field_mask;
    logic                sign_bit;
    logic [XLEN-1:0]     load_ext;
    logic                timeout_hit;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_rdata = rdata_q;
    assign out_err   = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_VAL);

    always_comb begin
        illegal   = 1'b0;
        lane_mask = NB'(1);
        case (in_size)
            2'd0: begin
                illegal   = 1'b0;
                lane_mask = NB'(1);
            end
            2'd1: begin
                illegal   = in_addr[0];
                lane_mask = NB'(2'h3);
            end
            2'd2: begin
                illegal   = |in_addr[1:0];
                lane_mask = NB'(4'hF);
            end
            default: begin
                illegal   = (|in_addr[2:0]) || (XLEN == 32);
                lane_mask = NB'(8'hFF);
            end
        endcase
    end

    // Bring the addressed field down to bit 0, then extend from its top bit.
    always_comb begin
        shifted    = bus_rdata >> {off_q, 3'b000};
        field_mask = '1;
        sign_bit   = shifted[XLEN-1];
        case (size_q)
            2'd0: begin
                field_mask = XLEN'(8'hFF);
                sign_bit   = shifted[7];
            end
            2'd1: begin
                field_mask = XLEN'(16'hFFFF);
                sign_bit   = shifted[15];
            end
            2'd2: begin
                field_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit   = shifted[31];
            end
            default: begin
                field_mask = '1;
                sign_bit   = shifted[XLEN-1];
            end
        endcase
        load_ext = (uns_q || !sign_bit) ? (shifted & field_mask) : (shifted | ~field_mask);
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        store_d     = store_q;
        // Saturate at TIMEOUT so a grant that wins on the limit still leaves WAIT bounded.
        cnt_d       = cnt_q;
        if ((state_q == S_REQ || state_q == S_WAIT) && cnt_q != TO_VAL)
            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_d   = '0;
                    off_d   = in_addr[OW-1:0];
                    size_d  = in_size;
                    uns_d   = in_unsigned;
                    store_d = in_store;
                    rdata_d = '0;
                    if (illegal) begin
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        err_d       = 2'd1;
                    end else begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = in_store;
                        bus_addr_d  = {in_addr[ADDR_W-1:OW], {OW{1'b0}}};
                        bus_wdata_d = in_wdata << {in_addr[OW-1:0], 3'b000};
                        bus_wmask_d = lane_mask << in_addr[OW-1:0];
                        err_d       = 2'd0;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d   = S_WAIT;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    out_valid_d = 1'b1;
                    err_d       = 2'd3;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_d     = S_RESP;
                    out_valid_d = 1'b1;
                    err_d       = bus_err ? 2'd2 : 2'd0;
                    rdata_d     = (!store_q && !bus_err) ? load_ext : '0;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    out_valid_d = 1'b1;
                    err_d       = 2'd3;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    rdata_d     = '0;
                    err_d       = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 2'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            off_q       <= '0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            store_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            store_q     <= store_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: the bench plays the memory bus with programmable grant/response
// delays and compares against an index-arithmetic reference model.
module tb_lsu_ctrl;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_store, in_unsigned;
    logic [63:0] in_addr, in_wdata;
    logic [1:0]  in_size;
    logic        out_valid, out_ready;
    logic [63:0] out_rdata;
    logic [1:0]  out_err;
    logic        bus_req, bus_gnt, bus_we, bus_rvalid, bus_err;
    logic [63:0] bus_addr, bus_wdata, bus_rdata;
    logic [7:0]  bus_wmask;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.XLEN(64), .ADDR_W(64), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_load(input logic [63:0] word, input int off, input int size,
                                             input bit uns);
        int nbits;
        logic [63:0] f, m;
        nbits = 8 << size;
        f = word >> (8 * off);
        if (nbits < 64) begin
            m = (64'd1 << nbits) - 64'd1;
            f = f & m;
            if (!uns && f[nbits-1]) f = f | ~m;
        end
        return f;
    endfunction

    // Reference: bus events happen at REQ+WAIT cycle index d1 (grant) and d1+1+d2 (response);
    // a timeout strikes at the first index >= T that carries no handshake.
    task automatic model(input logic [63:0] addr, input bit store, input logic [1:0] size,
                         input bit uns, input logic [63:0] rword, input bit berr,
                         input int d1, input int d2, output logic [1:0] e_err,
                         output logic [63:0] e_rdata, output int e_lat, output bit e_bus);
        int bytes, ri, w0, evt;
        bit to;
        bytes = 1 << size;
        e_rdata = 64'd0;
        if ((addr % bytes) != 0) begin
            e_err = 2'd1; e_lat = 0; e_bus = 1'b0;
        end else begin
            e_bus = 1'b1;
            if (d1 > T) begin
                evt = T; to = 1'b1;
            end else begin
                ri = d1 + 1 + d2;
                w0 = (T > d1 + 1) ? T : d1 + 1;
                if (ri <= w0) begin evt = ri; to = 1'b0; end
                else begin evt = w0; to = 1'b1; end
            end
            e_lat = evt + 1;
            e_err = to ? 2'd3 : (berr ? 2'd2 : 2'd0);
            if (e_err == 2'd0 && !store) e_rdata = ref_load(rword, int'(addr[2:0]), int'(size), uns);
        end
    endtask

    // Issues one request and serves the bus; returns at the negedge where out_valid is first seen
    // (lat = -1 if it never appears within the budget).
    task automatic run_access(input logic [63:0] addr, input logic [63:0] wdata, input bit store,
                              input logic [1:0] size, input bit uns, input logic [63:0] rword,
                              input bit berr, input int d1, input int d2,
                              output int lat, output bit req_seen, output logic [63:0] baddr,
                              output logic [63:0] bwdata, output logic [7:0] bmask, output logic bwe);
        int reqcnt, waitcnt;
        bit granted;
        reqcnt = 0; waitcnt = 0; granted = 1'b0;
        lat = -1; req_seen = 1'b0; baddr = '0; bwdata = '0; bmask = '0; bwe = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_store = store;
        in_size = size; in_unsigned = uns;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
        in_size = 2'($urandom); in_store = 1'($urandom); in_unsigned = 1'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = {$urandom, $urandom};
            if (bus_req) begin
                if (!req_seen) begin
                    baddr = bus_addr; bwdata = bus_wdata; bmask = bus_wmask; bwe = bus_we;
                end
                req_seen = 1'b1;
                if (reqcnt == d1) begin bus_gnt = 1'b1; granted = 1'b1; end
                reqcnt++;
            end else if (granted) begin
                if (waitcnt == d2) begin bus_rvalid = 1'b1; bus_rdata = rword; bus_err = berr; end
                waitcnt++;
            end
            @(negedge clk);
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    endtask

    task automatic release_resp;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if ({bus_req, bus_we} !== 2'b00) begin errors++; $display("FAIL reset_bus_req_we got %b want 00", {bus_req, bus_we}); end
        checks++; if ({out_rdata, out_err} !== 66'd0) begin errors++; $display("FAIL reset_out_data got %h/%h want 0/0", out_rdata, out_err); end
        checks++; if ({bus_addr, bus_wdata, bus_wmask} !== 136'd0) begin errors++; $display("FAIL reset_bus_fields got %h %h %h want 0", bus_addr, bus_wdata, bus_wmask); end
    endtask

    task automatic test_load_byte_signed;
        int lat; bit rs; logic [63:0] ba, bw; logic [7:0] bm; logic we;
        run_access(64'h8000_0003, 64'd0, 1'b0, 2'd0, 1'b0, 64'h1122_3344_8566_7788, 1'b0, 0, 0,
                   lat, rs, ba, bw, bm, we);
        checks++; if (ba !== 64'h8000_0000) begin errors++; $display("FAIL lb_bus_addr got %h want 80000000", ba); end
        checks++; if (bm !== 8'h08 || we !== 1'b0) begin errors++; $display("FAIL lb_mask_we got %h/%b want 08/0", bm, we); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lb_min_latency got %0d want 2", lat); end
        checks++; if (out_rdata !== 64'hFFFF_FFFF_FFFF_FF85) begin errors++; $display("FAIL lb_rdata got %h want ffffffffffffff85", out_rdata); end
        checks++; if (out_err !== 2'd0) begin errors++; $display("FAIL lb_err got %0d want 0", out_err); end
        release_resp();
    endtask

    task automatic test_store_half;
        int lat; bit rs; logic [63:0] ba, bw; logic [7:0] bm; logic we;
        run_access(64'h1000_0006, {16'h5A5A, 32'h1234_5678, 16'hABCD}, 1'b1, 2'd1, 1'b0,
                   64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1, 1, lat, rs, ba, bw, bm, we);
        checks++; if (bm !== 8'hC0) begin errors++; $display("FAIL sh_mask got %h want c0", bm); end
        checks++; if (bw[63:48] !== 16'hABCD) begin errors++; $display("FAIL sh_wdata got %h want abcd", bw[63:48]); end
        checks++; if (we !== 1'b1 || ba !== 64'h1000_0000) begin errors++; $display("FAIL sh_we_addr got %b/%h want 1/10000000", we, ba); end
        checks++; if (out_err !== 2'd0 || out_rdata !== 64'd0) begin errors++; $display("FAIL sh_resp got %0d/%h want 0/0", out_err, out_rdata); end
        release_resp();
    endtask

    task automatic test_misaligned;
        int lat; bit rs; logic [63:0] ba, bw; logic [7:0] bm; logic we;
        logic [63:0] addrs[3] = '{64'h2000_0002, 64'h2000_0004, 64'h2000_0001};
        logic [1:0]  sizes[3] = '{2'd2, 2'd3, 2'd1};
        for (int k = 0; k < 3; k++) begin
            run_access(addrs[k], 64'd0, 1'b0, sizes[k], 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0,
                       lat, rs, ba, bw, bm, we);
            checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mis_bus_touched[%0d] got %b want 0", k, rs); end
            checks++; if (lat < 0 || lat > 1) begin errors++; $display("FAIL mis_latency[%0d] got %0d want <=1", k, lat); end
            checks++; if (out_err !== 2'd1 || out_rdata !== 64'd0) begin errors++; $display("FAIL mis_resp[%0d] got %0d/%h want 1/0", k, out_err, out_rdata); end
            release_resp();
        end
    endtask

    task automatic test_timeout;
        int lat; bit rs; logic [63:0] ba, bw; logic [7:0] bm; logic we;
        int d1s[4]  = '{0, 100, 0, T};
        int d2s[4]  = '{100, 0, 3, 0};
        int lats[4] = '{T + 1, T + 1, T + 1, T + 2};
        logic [1:0] errs[4] = '{2'd3, 2'd3, 2'd0, 2'd0};
        for (int k = 0; k < 4; k++) begin
            run_access(64'h3000_0008, 64'd0, 1'b0, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0,
                       d1s[k], d2s[k], lat, rs, ba, bw, bm, we);
            checks++; if (lat !== lats[k]) begin errors++; $display("FAIL to_latency[%0d] got %0d want %0d", k, lat, lats[k]); end
            checks++; if (out_err !== errs[k]) begin errors++; $display("FAIL to_err[%0d] got %0d want %0d", k, out_err, errs[k]); end
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL to_bus_req[%0d] got %b want 0", k, bus_req); end
            release_resp();
            if (k == 0) begin
                bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 64'hFFFF_0000_FFFF_0000;
                @(negedge clk);
                bus_rvalid = 1'b0; bus_err = 1'b0;
                @(negedge clk);
                checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL to_late_rvalid got ov=%b ir=%b want 0/1", out_valid, in_ready); end
            end
        end
    endtask

    task automatic test_backpressure;
        int lat; bit rs; logic [63:0] ba, bw; logic [7:0] bm; logic we;
        logic [1:0] e_err; logic [63:0] e_rd; int e_lat; bit e_bus;
        logic [63:0] rw;
        rw = {$urandom, $urandom};
        model(64'h4000_0004, 1'b0, 2'd2, 1'b0, rw, 1'b0, 0, 1, e_err, e_rd, e_lat, e_bus);
        run_access(64'h4000_0004, 64'd0, 1'b0, 2'd2, 1'b0, rw, 1'b0, 0, 1, lat, rs, ba, bw, bm, we);
        in_valid = 1'b1; in_addr = 64'h4000_0010; in_size = 2'd0; in_store = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_rdata !== e_rd || out_err !== e_err || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got ov=%b rd=%h err=%0d ir=%b want 1/%h/%0d/0", c, out_valid, out_rdata, out_err, in_ready, e_rd, e_err);
            end
        end
        in_valid = 1'b0;
        release_resp();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%b ir=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_wait;
        int lat; bit rs; logic [63:0] ba, bw; logic [7:0] bm; logic we;
        logic [1:0] e_err; logic [63:0] e_rd; int e_lat; bit e_bus;
        logic [63:0] rw;
        @(negedge clk);
        in_valid = 1'b1; in_addr = 64'h5000_0010; in_size = 2'd2; in_store = 1'b1;
        in_wdata = 64'h1111_2222_3333_4444; in_unsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rm_req got %b want 1", bus_req); end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0) begin errors++; $display("FAIL rm_ctrl got ir=%b ov=%b req=%b we=%b want 1/0/0/0", in_ready, out_valid, bus_req, bus_we); end
        checks++; if ({out_rdata, out_err, bus_addr, bus_wdata, bus_wmask} !== 202'd0) begin errors++; $display("FAIL rm_data got %h %0d %h %h %h want 0", out_rdata, out_err, bus_addr, bus_wdata, bus_wmask); end
        bus_rvalid = 1'b1; bus_err = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_stray_rvalid got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        rw = {$urandom, $urandom};
        model(64'h5000_0018, 1'b0, 2'd3, 1'b0, rw, 1'b0, 0, 0, e_err, e_rd, e_lat, e_bus);
        run_access(64'h5000_0018, 64'd0, 1'b0, 2'd3, 1'b0, rw, 1'b0, 0, 0, lat, rs, ba, bw, bm, we);
        checks++; if (out_rdata !== e_rd || out_err !== e_err || lat !== e_lat) begin errors++; $display("FAIL rm_load_d got %h/%0d/%0d want %h/%0d/%0d", out_rdata, out_err, lat, e_rd, e_err, e_lat); end
        release_resp();
    endtask

    task automatic test_unsigned_half;
        int lat; bit rs; logic [63:0] ba, bw; logic [7:0] bm; logic we;
        run_access(64'h6000_0002, 64'd0, 1'b0, 2'd1, 1'b1, 64'h0000_0000_F00D_0000, 1'b0, 0, 0,
                   lat, rs, ba, bw, bm, we);
        checks++; if (out_rdata !== 64'h0000_0000_0000_F00D || out_err !== 2'd0) begin errors++; $display("FAIL luh_rdata got %h/%0d want f00d/0", out_rdata, out_err); end
        release_resp();
        run_access(64'h6000_0002, 64'd0, 1'b0, 2'd1, 1'b1, 64'h0000_0000_F00D_0000, 1'b1, 0, 0,
                   lat, rs, ba, bw, bm, we);
        checks++; if (out_err !== 2'd2 || out_rdata !== 64'd0) begin errors++; $display("FAIL luh_bus_err got %0d/%h want 2/0", out_err, out_rdata); end
        release_resp();
    endtask

    task automatic test_random;
        int lat; bit rs; logic [63:0] ba, bw; logic [7:0] bm; logic we;
        logic [1:0] e_err; logic [63:0] e_rd; int e_lat; bit e_bus;
        logic [63:0] addr, wd, rw, ew, bytem;
        logic [1:0] size; bit st, un, be; int d1, d2, off; logic [7:0] em;
        for (int n = 0; n < 60; n++) begin
            size = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
            st = 1'($urandom); un = 1'($urandom); be = ($urandom_range(0, 7) == 0);
            wd = {$urandom, $urandom}; rw = {$urandom, $urandom};
            d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 4);
            model(addr, st, size, un, rw, be, d1, d2, e_err, e_rd, e_lat, e_bus);
            run_access(addr, wd, st, size, un, rw, be, d1, d2, lat, rs, ba, bw, bm, we);
            checks++;
            if (out_err !== e_err || out_rdata !== e_rd) begin
                errors++;
                $display("FAIL rnd_resp[%0d] addr=%h size=%0d st=%b got %0d/%h want %0d/%h", n, addr, size, st, out_err, out_rdata, e_err, e_rd);
            end
            checks++;
            if (e_bus ? (lat !== e_lat) : (lat < 0 || lat > 1)) begin
                errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", n, lat, e_lat);
            end
            checks++; if (rs !== e_bus) begin errors++; $display("FAIL rnd_bus_used[%0d] got %b want %b", n, rs, e_bus); end
            if (e_bus) begin
                off = int'(addr[2:0]);
                em = 8'(((1 << (1 << size)) - 1) << off);
                ew = wd << (8 * off);
                for (int b = 0; b < 8; b++) bytem[b*8 +: 8] = {8{em[b]}};
                checks++;
                if (ba !== {addr[63:3], 3'b000} || bm !== em || we !== st) begin
                    errors++; $display("FAIL rnd_bus_ctl[%0d] got %h/%h/%b want %h/%h/%b", n, ba, bm, we, {addr[63:3], 3'b000}, em, st);
                end
                if (st) begin
                    checks++;
                    if ((bw & bytem) !== (ew & bytem)) begin
                        errors++; $display("FAIL rnd_wdata[%0d] got %h want %h", n, bw & bytem, ew & bytem);
                    end
                end
            end
            release_resp();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_store = 1'b0;
        in_size = 2'd0; in_unsigned = 1'b0; out_ready = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        test_reset();
        test_load_byte_signed();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_unsigned_half();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
